irq_pending_ctrl: RTL and testbench

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

---
 rtl/irq_pending_ctrl_pkg.sv | 14 +
 rtl/irq_pending_ctrl_prio_enc.sv | 20 ++
 rtl/irq_pending_ctrl.sv | 109 ++++++++++
 tb/tb_irq_pending_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants and FSM encoding for the interrupt pending controller.
// The encoder and the controller both use these widths.
package irq_pending_ctrl_pkg;

   localparam int unsigned      NUM_IRQ  = 8;
   localparam int unsigned      ID_W     = 3;
   localparam logic [NUM_IRQ-1:0] MASK_RST = 8'hFF;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

endpackage

// File: rtl/irq_pending_ctrl_prio_enc.sv
// 8-to-3 priority encoder: the highest set input bit wins.
// valid is low when no input bit is set, and out is 0 in that case.
module priority_encoder_8to3
   import irq_pending_ctrl_pkg::*;
(
   input  logic [NUM_IRQ-1:0] in,
   output logic [ID_W-1:0]    out,
   output logic               valid
);

   always_comb begin
      out   = '0;
      valid = |in;
      // Ascending scan: the last hit is the highest index.
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (in[i]) out = i[ID_W-1:0];
      end
   end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: captures request lines into a pending register,
// filters them through a mask and presents one request at a time until acked.
module irq_pending_ctrl
   import irq_pending_ctrl_pkg::*;
#(
   parameter int unsigned EDGE_MODE = 1
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_wr,
   input  logic [NUM_IRQ-1:0] mask_data,
   input  logic               irq_ack,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] mask,
   output state_t             dbg_state
);

   // Handshake: irq_req/irq_id are held stable from the IDLE->REQ edge until
   // the first edge with irq_ack=1; irq_ack outside REQ has no effect.

   logic [NUM_IRQ-1:0] r_irq_q;
   logic [NUM_IRQ-1:0] r_pending;
   logic [NUM_IRQ-1:0] r_mask;
   logic [ID_W-1:0]    r_irq_id;
   logic               r_irq_req;
   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_load_id;
   logic               w_ack_take;
   logic [NUM_IRQ-1:0] w_set;
   logic [NUM_IRQ-1:0] w_clr;
   logic [NUM_IRQ-1:0] w_eligible;
   logic [ID_W-1:0]    w_enc_idx;
   logic               w_enc_valid;

   generate
      if (EDGE_MODE != 0) begin : g_edge
         assign w_set = irq_in & ~r_irq_q;
      end else begin : g_level
         assign w_set = irq_in;
      end
   endgenerate

   assign w_eligible = r_pending & ~r_mask;
   assign w_ack_take = (r_state == REQ) && irq_ack;
   // Set is OR-ed in after the clear so a same-edge set wins over the ack.
   assign w_clr      = w_ack_take ? (NUM_IRQ'(1) << r_irq_id) : '0;

   priority_encoder_8to3 u_prio_enc (
      .in    (w_eligible),
      .out   (w_enc_idx),
      .valid (w_enc_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_q   <= '0;
         r_pending <= '0;
         r_mask    <= MASK_RST;
      end else begin
         r_irq_q   <= irq_in;
         r_pending <= (r_pending & ~w_clr) | w_set;
         if (mask_wr) r_mask <= mask_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_id   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_enc_valid) begin
               w_state_nxt = REQ;
               w_load_id   = 1'b1;
            end
         end
         REQ: begin
            if (irq_ack) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_id  <= '0;
         r_irq_req <= 1'b0;
      end else begin
         if (w_load_id) r_irq_id <= w_enc_idx;
         r_irq_req <= (w_state_nxt == REQ);
      end
   end

   assign irq_req   = r_irq_req;
   assign irq_id    = r_irq_id;
   assign pending   = r_pending;
   assign mask      = r_mask;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: one edge-mode and one level-mode instance share
// inputs; an event-level model predicts pending, mask and the presented request.
module tb_irq_pending_ctrl;
   import irq_pending_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] irq_in = '0;
   logic       mask_wr = 1'b0;
   logic [7:0] mask_data = '0;
   logic       irq_ack = 1'b0;

   logic       e_req, l_req;
   logic [2:0] e_id, l_id;
   logic [7:0] e_pend, l_pend, e_mask, l_mask;
   state_t     e_st, l_st;

   int n_cmp = 0;
   int n_err = 0;

   // model state, index 1 = edge mode, 0 = level mode
   bit [7:0] m_pend [2];
   bit       m_busy [2];
   int       m_id   [2];
   bit [7:0] m_mask;
   bit [7:0] m_prev;

   always #5 clk = ~clk;

   irq_pending_ctrl #(.EDGE_MODE(1)) u_dut_edge (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr),
      .mask_data(mask_data), .irq_ack(irq_ack), .irq_req(e_req),
      .irq_id(e_id), .pending(e_pend), .mask(e_mask), .dbg_state(e_st)
   );

   irq_pending_ctrl #(.EDGE_MODE(0)) u_dut_lvl (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr),
      .mask_data(mask_data), .irq_ack(irq_ack), .irq_req(l_req),
      .irq_id(l_id), .pending(l_pend), .mask(l_mask), .dbg_state(l_st)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         m_pend[m] = '0;
         m_busy[m] = 1'b0;
         m_id[m]   = 0;
      end
      m_mask = 8'hFF;
      m_prev = '0;
   endfunction

   // One clock edge worth of behaviour, evaluated from pre-edge values.
   function automatic void model_edge(input bit [7:0] irq, input bit mwr,
                                      input bit [7:0] md, input bit ack);
      for (int m = 0; m < 2; m++) begin
         bit [7:0] nxt;
         nxt = m_pend[m];
         if (m_busy[m]) begin
            if (ack) begin
               nxt[m_id[m]] = 1'b0;
               m_busy[m] = 1'b0;
            end
         end else begin
            for (int i = 7; i >= 0; i--) begin
               if (m_pend[m][i] && !m_mask[i]) begin
                  m_busy[m] = 1'b1;
                  m_id[m]   = i;
                  break;
               end
            end
         end
         for (int i = 0; i < 8; i++) begin
            if (irq[i] && (m == 0 || !m_prev[i])) nxt[i] = 1'b1;
         end
         m_pend[m] = nxt;
      end
      if (mwr) m_mask = md;
      m_prev = irq;
   endfunction

   task automatic compare_all();
      check("edge_req",  {7'd0, e_req}, {7'd0, m_busy[1]});
      check("edge_id",   {5'd0, e_id},  8'(m_id[1]));
      check("edge_pend", e_pend, m_pend[1]);
      check("edge_mask", e_mask, m_mask);
      check("lvl_req",   {7'd0, l_req}, {7'd0, m_busy[0]});
      check("lvl_id",    {5'd0, l_id},  8'(m_id[0]));
      check("lvl_pend",  l_pend, m_pend[0]);
      check("lvl_mask",  l_mask, m_mask);
   endtask

   // Called just after a negedge; returns just after the following negedge.
   task automatic step(input logic [7:0] irq, input logic mwr,
                       input logic [7:0] md, input logic ack);
      irq_in = irq; mask_wr = mwr; mask_data = md; irq_ack = ack;
      @(posedge clk);
      model_edge(irq, mwr, md, ack);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      model_reset();
      check("rst_req",  {7'd0, e_req}, 8'd0);
      check("rst_pend", e_pend, 8'h00);
      check("rst_mask", e_mask, 8'hFF);
      check("rst_id",   {5'd0, e_id}, 8'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic expect_req(input string tag, input logic req, input logic [2:0] id);
      check({tag, "_req"}, {7'd0, e_req}, {7'd0, req});
      if (req) check({tag, "_id"}, {5'd0, e_id}, {5'd0, id});
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // single pulse, unmasked
      step(8'h00, 1'b1, 8'h00, 1'b0);
      step(8'h08, 1'b0, 8'h00, 1'b0);
      check("p1_pend", e_pend, 8'h08);
      expect_req("p1_n", 1'b0, 3'd0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      expect_req("p1_n1", 1'b1, 3'd3);
      step(8'h00, 1'b0, 8'h00, 1'b1);
      check("p1_ack_pend", e_pend, 8'h00);
      expect_req("p1_ack", 1'b0, 3'd0);

      // two lines together, higher index first, one-cycle gap
      step(8'h22, 1'b0, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      expect_req("two_a", 1'b1, 3'd5);
      step(8'h00, 1'b0, 8'h00, 1'b1);
      expect_req("two_gap", 1'b0, 3'd0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      expect_req("two_b", 1'b1, 3'd1);
      step(8'h00, 1'b0, 8'h00, 1'b1);

      // higher priority arrives while busy
      step(8'h04, 1'b0, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      expect_req("hold_a", 1'b1, 3'd2);
      step(8'h80, 1'b0, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      expect_req("hold_b", 1'b1, 3'd2);
      check("hold_pend", e_pend, 8'h84);
      step(8'h00, 1'b0, 8'h00, 1'b1);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      expect_req("hold_c", 1'b1, 3'd7);
      step(8'h00, 1'b0, 8'h00, 1'b1);

      // masked pending, then unmask
      step(8'h00, 1'b1, 8'hFE, 1'b0);
      step(8'h10, 1'b0, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      check("mask_pend", e_pend, 8'h10);
      expect_req("mask_idle", 1'b0, 3'd0);
      step(8'h00, 1'b1, 8'h00, 1'b0);
      expect_req("mask_wr_edge", 1'b0, 3'd0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      expect_req("mask_open", 1'b1, 3'd4);
      step(8'h00, 1'b0, 8'h00, 1'b1);

      // ack collides with a new edge on the same bit
      step(8'h40, 1'b0, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      expect_req("coll_a", 1'b1, 3'd6);
      step(8'h40, 1'b0, 8'h00, 1'b1);
      check("coll_pend", e_pend, 8'h40);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      expect_req("coll_b", 1'b1, 3'd6);

      // reset while busy, line held high across reset
      irq_in = 8'h01;
      #1;
      do_reset();
      step(8'h01, 1'b0, 8'h00, 1'b0);
      check("post_rst_edge", e_pend, 8'h01);
      check("post_rst_lvl",  l_pend, 8'h01);
      step(8'h01, 1'b0, 8'h00, 1'b0);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         logic [7:0] irq, md;
         logic mwr, ack;
         irq = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         mwr = ($urandom_range(0, 7) == 0);
         md  = 8'($urandom & $urandom);
         ack = ($urandom_range(0, 1) == 1);
         step(irq, mwr, md, ack);
         if (c == 200) begin
            irq_in = 8'($urandom);
            #1;
            do_reset();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
